// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: x - y one bit per clock, LSB first,
// with start/ready handshake, single-cycle done pulse and borrow-out.
module serial_subtractor #(
    parameter int unsigned SIZE = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [SIZE-1:0] dinx_i,
    input  logic [SIZE-1:0] diny_i,
    output logic            ready_o,
    output logic            done_o,
    output logic [SIZE-1:0] diff_o,
    output logic            bout_o
);

    localparam int unsigned CW = $clog2(SIZE) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [SIZE-1:0] x_q, x_d;
    logic [SIZE-1:0] y_q, y_d;
    logic [SIZE-1:0] res_q, res_d;
    logic [SIZE-1:0] diff_q, diff_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            borrow_q, borrow_d;
    logic            bout_q, bout_d;
    logic            done_q, done_d;
    logic            ready_q, ready_d;

    logic            x0_c, y0_c, dbit_c, borrow_nxt_c, last_c;

    // One full-subtractor slice on the current LSBs
    always_comb begin
        x0_c         = x_q[0];
        y0_c         = y_q[0];
        dbit_c       = x0_c ^ y0_c ^ borrow_q;
        borrow_nxt_c = (~x0_c & y0_c) | (~(x0_c ^ y0_c) & borrow_q);
        last_c       = (cnt_q == CW'(SIZE - 1));
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    x_d      = dinx_i;
                    y_d      = diny_i;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                x_d      = {1'b0, x_q[SIZE-1:1]};
                y_d      = {1'b0, y_q[SIZE-1:1]};
                res_d    = {dbit_c, res_q[SIZE-1:1]};
                borrow_d = borrow_nxt_c;
                cnt_d    = cnt_q + CW'(1);
                // Result is published only on the final bit
                if (last_c) begin
                    diff_d  = {dbit_c, res_q[SIZE-1:1]};
                    bout_d  = borrow_nxt_c;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign diff_o  = diff_q;
    assign bout_o  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: SIZE=4 and SIZE=16 instances,
// expected results queued at issue time and checked on every done pulse.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start4, start16;
    logic [3:0]  x4, y4;
    logic [15:0] x16, y16;
    logic        rdy4, done4, bout4, rdy16, done16, bout16;
    logic [3:0]  diff4;
    logic [15:0] diff16;

    logic [4:0]  q4[$];
    logic [16:0] q16[$];
    int          total  = 0;
    int          passed = 0;
    int          dcount4 = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.SIZE(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start4),
        .dinx_i(x4), .diny_i(y4),
        .ready_o(rdy4), .done_o(done4), .diff_o(diff4), .bout_o(bout4)
    );

    serial_subtractor #(.SIZE(16)) dut16 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start16),
        .dinx_i(x16), .diny_i(y16),
        .ready_o(rdy16), .done_o(done16), .diff_o(diff16), .bout_o(bout16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitors: pop and compare on every done pulse
    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            dcount4++;
            if (q4.size() == 0) chk("unexpected_done4", {27'd0, bout4, diff4}, 32'hFFFF_FFFF);
            else chk("result4", {27'd0, bout4, diff4}, {27'd0, q4.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (done16 === 1'b1) begin
            if (q16.size() == 0) chk("unexpected_done16", {15'd0, bout16, diff16}, 32'hFFFF_FFFF);
            else chk("result16", {15'd0, bout16, diff16}, {15'd0, q16.pop_front()});
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge
    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic [4:0] exp);
        int guard = 0;
        while (rdy4 !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) chk("ready4_timeout", 32'd0, 32'd1);
        start4 = 1'b1; x4 = x; y4 = y;
        q4.push_back(exp);
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    task automatic op16(input logic [15:0] x, input logic [15:0] y);
        int guard = 0;
        logic [16:0] e;
        while (rdy16 !== 1'b1 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 100) chk("ready16_timeout", 32'd0, 32'd1);
        e = {1'b0, x} - {1'b0, y};
        start16 = 1'b1; x16 = x; y16 = y;
        q16.push_back(e);
        @(posedge clk); #1;
        start16 = 1'b0;
    endtask

    task automatic drain;
        int guard = 0;
        while ((q4.size() != 0 || q16.size() != 0) && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 200) chk("drain_timeout", 32'(q4.size() + q16.size()), 32'd0);
    endtask

    initial begin
        int t1, t2, nd;
        logic [4:0] e4;
        logic [7:0] ij;

        rst_n = 1'b0; start4 = 1'b0; start16 = 1'b0;
        x4 = '0; y4 = '0; x16 = '0; y16 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, rdy4}, 32'd1);
        chk("rst_done", {31'd0, done4}, 32'd0);
        chk("rst_diff", {28'd0, diff4}, 32'd0);
        chk("rst_bout", {31'd0, bout4}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: latency, ready low for SIZE cycles, result held during RUN
        op4(4'hF, 4'h1, 5'h0E);
        for (int k = 1; k <= 4; k++) begin
            chk("t1_ready_low", {31'd0, rdy4}, 32'd0);
            chk("t1_no_early_done", {31'd0, done4}, 32'd0);
            chk("t1_diff_held", {28'd0, diff4}, 32'd0);
            @(posedge clk); #1;
        end
        chk("t1_done_pulse", {31'd0, done4}, 32'd1);
        chk("t1_ready_back", {31'd0, rdy4}, 32'd1);
        chk("t1_diff", {28'd0, diff4}, 32'hE);
        chk("t1_bout", {31'd0, bout4}, 32'd0);
        @(posedge clk); #1;
        chk("t1_done_single", {31'd0, done4}, 32'd0);
        chk("t1_diff_stays", {28'd0, diff4}, 32'hE);

        // Test 2: borrow cases and equal operands
        op4(4'h1, 4'hF, 5'h12);
        op4(4'h0, 4'h1, 5'h1F);
        op4(4'h5, 4'h5, 5'h00);
        drain();

        // Test 3: start held high, back-to-back operations
        @(posedge clk); #1;
        start4 = 1'b1; x4 = 4'h9; y4 = 4'h3;
        q4.push_back(5'h06);
        @(posedge clk); #1;
        x4 = 4'h3; y4 = 4'h9;
        q4.push_back(5'h1A);
        t1 = -1; t2 = -1; nd = 0;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk); #1;
            if (done4 === 1'b1) begin
                nd++;
                if (t1 < 0) t1 = n;
                else if (t2 < 0) t2 = n;
            end
            if (t1 > 0 && n == t1 + 1) start4 = 1'b0;
        end
        start4 = 1'b0;
        chk("t3_first_done_cycle", 32'(t1), 32'd4);
        chk("t3_done_spacing", 32'(t2 - t1), 32'd5);
        chk("t3_done_count", 32'(nd), 32'd2);
        drain();

        // Test 4: start and operand changes during RUN are ignored
        op4(4'h8, 4'h2, 5'h06);
        start4 = 1'b1; x4 = 4'hF; y4 = 4'hF;
        @(posedge clk); #1;
        start4 = 1'b0; x4 = 4'h0; y4 = 4'h7;
        nd = 0;
        for (int n = 2; n <= 10; n++) begin
            if (done4 === 1'b1) nd++;
            @(posedge clk); #1;
        end
        chk("t4_done_count", 32'(nd), 32'd1);
        chk("t4_diff", {28'd0, diff4}, 32'h6);

        // Test 5: asynchronous reset mid-RUN aborts without done
        op4(4'hC, 4'h5, 5'h07);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        q4.delete();
        chk("t5_rst_diff", {28'd0, diff4}, 32'd0);
        chk("t5_rst_bout", {31'd0, bout4}, 32'd0);
        chk("t5_rst_ready", {31'd0, rdy4}, 32'd1);
        chk("t5_rst_done", {31'd0, done4}, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        nd = dcount4;
        repeat (8) begin
            @(posedge clk); #1;
        end
        chk("t5_no_done_after_abort", 32'(dcount4 - nd), 32'd0);
        op4(4'hC, 4'h5, 5'h07);
        drain();

        // Test 6a: exhaustive SIZE=4 against an (SIZE+1)-bit model
        for (int i = 0; i < 256; i++) begin
            ij = 8'(i);
            e4 = {1'b0, ij[7:4]} - {1'b0, ij[3:0]};
            op4(ij[7:4], ij[3:0], e4);
        end
        drain();

        // Test 6b: SIZE=16 corners plus random pairs
        op16(16'h0000, 16'hFFFF);
        op16(16'hFFFF, 16'h0000);
        op16(16'h8000, 16'h8001);
        for (int i = 0; i < 1000; i++) begin
            op16(16'($urandom), 16'($urandom));
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got %0d expected 0", 1);
        $fatal(1, "timeout");
    end

endmodule
